stream_mux_rr: RTL and testbench

- Parametrised N-channel stream multiplexer with enable, and the successor to the 2:1 combinational enable-mux.
- Each input channel has a valid/ready handshake; the block forwards one word per cycle to a single registered output stream.
- Two modes: fixed-select (SEL picks the channel) and round-robin arbitration across all requesting channels.
- Sits between multiple producers and one shared consumer (bus, FIFO or display path).

---
 rtl/stream_mux_rr.sv | 131 +++++++++++++
 tb/tb_stream_mux_rr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with enable, fixed-select or
// round-robin arbitration, and a single registered output slot.
module stream_mux_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      E,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          S,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          Y,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_ch,
    input  logic                      out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   y_r;
    logic [SEL_W-1:0]   out_ch_r;
    logic [SEL_W-1:0]   last_grant_r;

    logic [SEL_W-1:0]   grant_s;
    logic               eligible_s;
    logic               slot_free_s;
    logic               grant_valid_s;
    logic               transfer_s;
    logic [WIDTH-1:0]   sel_data_s;
    int                 dist_s;
    int                 best_dist_s;

    // Choose the candidate channel: S in fixed mode, else nearest requester after last_grant.
    always_comb begin
        grant_s     = {SEL_W{1'b0}};
        eligible_s  = 1'b0;
        dist_s      = 0;
        best_dist_s = CHANNELS;
        if (mode == 1'b0) begin
            if (int'(S) < CHANNELS) begin
                grant_s    = S;
                eligible_s = 1'b1;
            end else begin
                eligible_s = 1'b0;
            end
        end else begin
            // Distance 0 is the channel right after last_grant; last_grant itself is farthest.
            for (int c = 0; c < CHANNELS; c++) begin
                dist_s = c - int'(last_grant_r) - 1;
                if (dist_s < 0) begin
                    dist_s = dist_s + CHANNELS;
                end else begin
                    dist_s = dist_s;
                end
                if (in_valid[c] && (dist_s < best_dist_s)) begin
                    best_dist_s = dist_s;
                    grant_s     = SEL_W'(c);
                    eligible_s  = 1'b1;
                end else begin
                    best_dist_s = best_dist_s;
                end
            end
        end
    end

    assign slot_free_s   = (state_r == ST_EMPTY) || out_ready;
    assign grant_valid_s = rst_n && E && slot_free_s && eligible_s;

    // One-hot accept towards the granted channel only.
    always_comb begin
        in_ready = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = grant_valid_s && (int'(grant_s) == i);
        end
    end

    assign transfer_s = |(in_ready & in_valid);

    // Data of the granted channel, loaded only on a transfer.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(grant_s) == i) begin
                sel_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Output slot: load on transfer, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            y_r          <= {WIDTH{1'b0}};
            out_ch_r     <= {SEL_W{1'b0}};
            last_grant_r <= SEL_W'(CHANNELS - 1);
        end else begin
            case (state_r)
                ST_EMPTY, ST_FULL: begin
                    if (transfer_s) begin
                        state_r      <= ST_FULL;
                        y_r          <= sel_data_s;
                        out_ch_r     <= grant_s;
                        last_grant_r <= grant_s;
                    end else if ((state_r == ST_FULL) && out_ready) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign Y         = y_r;
    assign out_ch    = out_ch_r;
    assign out_valid = (state_r == ST_FULL);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr (3 channels, 2-bit select): directed vector table,
// asynchronous reset sequence and randomized traffic against a reference model.
module tb_stream_mux_rr;

    localparam int WIDTH = 4;
    localparam int CH    = 3;
    localparam int SEL_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                E;
    logic                mode;
    logic [SEL_W-1:0]    S;
    logic [CH-1:0]       in_valid;
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_ready;
    logic [WIDTH-1:0]    Y;
    logic                out_valid;
    logic [SEL_W-1:0]    out_ch;
    logic                out_ready;

    stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .S(S),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .Y(Y), .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the word in the output slot and the last granted channel.
    int m_valid, m_y, m_ch, m_lg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_y = 0; m_ch = 0; m_lg = CH - 1;
    endtask

    // Which channel the rules offer a slot to this cycle, -1 if none.
    function automatic int m_grant();
        if (E !== 1'b1) return -1;
        if (m_valid == 1 && out_ready !== 1'b1) return -1;
        if (mode == 1'b0) return (int'(S) < CH) ? int'(S) : -1;
        for (int k = 1; k <= CH; k++) begin
            if (in_valid[(m_lg + k) % CH]) return (m_lg + k) % CH;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_ready();
        int g;
        logic [31:0] r;
        g = m_grant();
        r = 32'd0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_update();
        int g;
        g = m_grant();
        if (g >= 0 && in_valid[g]) begin
            m_valid = 1; m_y = int'(in_data[g*WIDTH +: WIDTH]); m_ch = g; m_lg = g;
        end else if (m_valid == 1 && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model();
        chk("model_in_ready", 32'(in_ready), m_ready());
        chk("model_out_valid", 32'(out_valid), 32'(m_valid));
        chk("model_Y", 32'(Y), 32'(m_y));
        chk("model_out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic          rst;
        logic          en;
        logic          md;
        logic [1:0]    sel;
        logic [2:0]    vld;
        logic [11:0]   dat;
        logic          ordy;
        logic [2:0]    e_rdy;
        logic          e_v;
        logic [3:0]    e_y;
        logic [1:0]    e_ch;
    } vec_t;

    vec_t tbl [20];

    initial begin
        // rst en md sel vld dat ordy | rdy v y ch
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'd1, 3'b011, 12'h0A3, 1'b1, 3'b010, 1'b1, 4'hA, 2'd1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd1, 3'b011, 12'h0A3, 1'b1, 3'b010, 1'b1, 4'hA, 2'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b001, 1'b1, 4'h8, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b010, 1'b1, 4'h9, 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b100, 1'b1, 4'hA, 2'd2};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b001, 1'b1, 4'h8, 2'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd2, 3'b100, 12'h598, 1'b1, 3'b100, 1'b1, 4'h5, 2'd2};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 12'h596, 1'b0, 3'b000, 1'b1, 4'h5, 2'd2};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 12'h596, 1'b0, 3'b000, 1'b1, 4'h5, 2'd2};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 12'h596, 1'b0, 3'b000, 1'b1, 4'h5, 2'd2};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 12'h596, 1'b1, 3'b001, 1'b1, 4'h6, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b0, 3'b000, 1'b1, 4'h6, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b000, 1'b0, 4'h6, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b000, 1'b0, 4'h6, 2'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 2'd0, 3'b111, 12'hA98, 1'b1, 3'b010, 1'b1, 4'h9, 2'd1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 2'd3, 3'b111, 12'hA98, 1'b1, 3'b000, 1'b0, 4'h9, 2'd1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 2'd3, 3'b111, 12'hA98, 1'b1, 3'b000, 1'b0, 4'h9, 2'd1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 2'd0, 3'b001, 12'hA97, 1'b1, 3'b001, 1'b1, 4'h7, 2'd0};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 2'd0, 3'b100, 12'hC97, 1'b1, 3'b100, 1'b1, 4'hC, 2'd2};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 2'd1, 3'b000, 12'hC97, 1'b1, 3'b010, 1'b0, 4'hC, 2'd2};

        rst_n = 1'b1; E = 1'b0; mode = 1'b0; S = 2'd0;
        in_valid = 3'b000; in_data = 12'h000; out_ready = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_Y", 32'(Y), 32'd0);
        chk("reset_out_ch", 32'(out_ch), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rst) do_reset();
            E = tbl[i].en; mode = tbl[i].md; S = tbl[i].sel;
            in_valid = tbl[i].vld; in_data = tbl[i].dat; out_ready = tbl[i].ordy;
            #1;
            check_model();
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            model_update();
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
            chk($sformatf("tbl%0d_Y", i), 32'(Y), 32'(tbl[i].e_y));
            chk($sformatf("tbl%0d_out_ch", i), 32'(out_ch), 32'(tbl[i].e_ch));
        end

        // Asynchronous reset between edges while a word is held
        E = 1'b1; mode = 1'b1; in_valid = 3'b111; in_data = 12'hA98; out_ready = 1'b0;
        step();
        chk("areset_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_Y", 32'(Y), 32'd0);
        chk("areset_out_ch", 32'(out_ch), 32'd0);
        chk("areset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("areset_first_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("areset_first_Y", 32'(Y), 32'h8);
        chk("areset_first_ch", 32'(out_ch), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            E         = ($urandom_range(0, 7) != 0);
            mode      = 1'($urandom_range(0, 1));
            S         = 2'($urandom_range(0, 3));
            in_valid  = 3'($urandom);
            in_data   = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
